// File: rtl/mem_apb_ws.sv
// mem_apb_ws: APB3/APB4 completer backed by a word-addressed register-file
// memory. It supports programmable read and write wait states, byte strobes
// and an error response for misaligned or out-of-range addresses.
//
// Ports
//   PCLK     clock; every register updates on the rising edge
//   PRESET   synchronous reset, active-high
//   PSEL     slave select
//   PENABLE  access phase
//   PADDR    byte address; the word index is PADDR >> 2
//   PWRITE   1 = write, 0 = read
//   PWDATA   write data
//   PSTRB    byte-lane write enables (writes only)
//   PPROT    protection attributes (ignored)
//   PRDATA   read data, captured during the setup phase
//   PREADY   the transfer completes in this cycle
//   PSLVERR  error response, qualified by PREADY
module mem_apb_ws #(
  parameter int WIDTH_PAD = 32,
  parameter int WIDTH_PDA = 32,
  parameter int WIDTH_PDS = WIDTH_PDA/8,
  parameter int DEPTH     = 1024,
  parameter int WAIT_RD   = 1,
  parameter int WAIT_WR   = 0
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic [WIDTH_PAD-1:0] PADDR,
  input  logic                 PWRITE,
  input  logic [WIDTH_PDA-1:0] PWDATA,
  input  logic [WIDTH_PDS-1:0] PSTRB,
  input  logic [2:0]           PPROT,
  output logic [WIDTH_PDA-1:0] PRDATA,
  output logic                 PREADY,
  output logic                 PSLVERR
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e               state_q;
  logic [3:0]           cnt_q;
  logic [IW-1:0]        idx_q;
  logic                 err_q;
  logic                 wr_q;
  logic [WIDTH_PDA-1:0] prdata_q;

  logic [WIDTH_PDA-1:0] mem [DEPTH];

  // The full-width index is used for the range check, so addresses far
  // beyond DEPTH cannot alias back into the array. The array itself is
  // indexed with the truncated index.
  logic [WIDTH_PAD-1:0] idx_full;
  logic [IW-1:0]        idx_d;
  logic                 err_d;
  logic                 setup_ph;
  logic                 access_ph;
  logic                 ready;
  logic                 mem_we;

  assign idx_full  = PADDR >> 2;
  assign idx_d     = idx_full[IW-1:0];
  assign err_d     = (PADDR[1:0] != 2'b00) | (idx_full >= WIDTH_PAD'(DEPTH));
  assign setup_ph  = PSEL & ~PENABLE;
  assign access_ph = PSEL & PENABLE;

  // PREADY is decoded only from registered state, so it does not depend
  // combinationally on any bus input.
  assign ready  = (state_q == ACCESS) && (cnt_q == 4'd0);

  // A reset that coincides with completion discards the pending write.
  assign mem_we = ready & access_ph & wr_q & ~err_q & ~PRESET;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      wr_q     <= 1'b0;
      prdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (setup_ph) begin
            idx_q   <= idx_d;
            err_q   <= err_d;
            wr_q    <= PWRITE;
            cnt_q   <= PWRITE ? 4'(WAIT_WR) : 4'(WAIT_RD);
            if (!PWRITE)
              prdata_q <= err_d ? '0 : mem[idx_d];
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (!PSEL) begin
            // The requester abandoned the transfer, so return without writing.
            state_q <= IDLE;
          end else if (PENABLE) begin
            if (cnt_q != 4'd0) cnt_q   <= cnt_q - 4'd1;
            else               state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The memory array has no reset.
  always_ff @(posedge PCLK) begin
    for (int i = 0; i < WIDTH_PDS; i++) begin
      if (mem_we && PSTRB[i])
        mem[idx_q][8*i +: 8] <= PWDATA[8*i +: 8];
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = ready;
  assign PSLVERR = ready & err_q;

  logic unused_prot;
  assign unused_prot = ^PPROT;

endmodule
